// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing decoder: measures incoming hsync/vsync, locks onto a
// stable raster and regenerates the active flag and pixel coordinates.
module vga_sync_decoder #(
  parameter int H_BACK_PORCH = 48,
  parameter int H_ACTIVE     = 640,
  parameter int V_BACK_PORCH = 32,
  parameter int V_ACTIVE     = 480
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pixel_strobe,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       mode,
  output logic [9:0] x,
  output logic [8:0] y,
  output logic       active,
  output logic       locked,
  output logic       line_start,
  output logic       frame_start,
  output logic [9:0] h_total,
  output logic [9:0] v_total,
  output logic       error
);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_e;

  localparam logic [9:0]  CNT_MAX = 10'd1023;
  localparam logic [10:0] H_LO    = 11'(H_BACK_PORCH);
  localparam logic [10:0] H_HI    = 11'(H_BACK_PORCH + H_ACTIVE);
  localparam logic [10:0] V_LO    = 11'(V_BACK_PORCH);
  localparam logic [10:0] V_HI    = 11'(V_BACK_PORCH + V_ACTIVE);
  localparam logic [9:0]  H_OFF   = 10'(H_BACK_PORCH);
  localparam logic [9:0]  V_OFF   = 10'(V_BACK_PORCH);

  state_e     state_q, state_d;
  logic       hs_prev_q, hs_prev_d;
  logic       vs_prev_q, vs_prev_d;
  logic [9:0] hc_q, hc_d;
  logic [9:0] vc_q, vc_d;
  logic [9:0] h_ref_q, h_ref_d;
  logic       h_ref_valid_q, h_ref_valid_d;
  logic [9:0] h_total_q, h_total_d;
  logic [9:0] v_total_q, v_total_d;
  logic [9:0] x_q, x_d;
  logic [8:0] y_q, y_d;
  logic       active_q, active_d;
  logic       locked_q, locked_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;
  logic       error_q, error_d;

  logic       hs_rise, vs_rise, fail, in_h, in_v;
  logic [9:0] line_len, x_off, y_off, y_shift;

  always_comb begin
    state_d       = state_q;
    hs_prev_d     = hs_prev_q;
    vs_prev_d     = vs_prev_q;
    hc_d          = hc_q;
    vc_d          = vc_q;
    h_ref_d       = h_ref_q;
    h_ref_valid_d = h_ref_valid_q;
    h_total_d     = h_total_q;
    v_total_d     = v_total_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    error_d       = 1'b0;
    fail          = 1'b0;
    hs_rise       = pixel_strobe & hsync & ~hs_prev_q;
    vs_rise       = pixel_strobe & vsync & ~vs_prev_q;
    line_len      = hc_q + 10'd1;

    if (pixel_strobe) begin
      hs_prev_d = hsync;
      vs_prev_d = vsync;
      if (hs_rise)
        hc_d = '0;
      else if (hc_q != CNT_MAX)
        hc_d = hc_q + 10'd1;
      if (vs_rise)
        vc_d = '0;
      else if (hs_rise && vc_q != CNT_MAX)
        vc_d = vc_q + 10'd1;

      // A line that never ends means the source vanished or stalled.
      if (state_q != SEARCH && hc_d == CNT_MAX)
        fail = 1'b1;

      case (state_q)
        SEARCH: begin
          if (vs_rise) begin
            state_d       = MEASURE;
            h_ref_valid_d = 1'b0;
          end
        end
        MEASURE: begin
          if (hs_rise) begin
            if (!h_ref_valid_q) begin
              h_ref_d       = line_len;
              h_ref_valid_d = 1'b1;
            end else if (line_len != h_ref_q) begin
              fail = 1'b1;
            end
          end
          // Totals only update on a clean lock so they survive lock loss.
          if (vs_rise && h_ref_valid_q && !fail) begin
            h_total_d = h_ref_q;
            v_total_d = vc_q;
            state_d   = LOCKED;
          end
        end
        LOCKED: begin
          if ((hs_rise && line_len != h_total_q) || (vs_rise && vc_q != v_total_q))
            fail = 1'b1;
        end
        default: state_d = SEARCH;
      endcase

      if (fail) begin
        state_d = SEARCH;
        error_d = 1'b1;
      end
      line_start_d  = hs_rise && (state_d == LOCKED);
      frame_start_d = vs_rise && (state_d == LOCKED);
    end

    // Coordinates recompute every clock so a mode change shows up without a strobe.
    in_h     = ({1'b0, hc_d} >= H_LO) && ({1'b0, hc_d} < H_HI);
    in_v     = ({1'b0, vc_d} >= V_LO) && ({1'b0, vc_d} < V_HI);
    active_d = (state_d == LOCKED) && in_h && in_v;
    locked_d = (state_d == LOCKED);
    x_off    = hc_d - H_OFF;
    y_off    = vc_d - V_OFF;
    y_shift  = y_off >> mode;
    x_d      = active_d ? (x_off >> mode) : '0;
    y_d      = active_d ? y_shift[8:0] : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= SEARCH;
      hs_prev_q     <= 1'b1;
      vs_prev_q     <= 1'b1;
      hc_q          <= '0;
      vc_q          <= '0;
      h_ref_q       <= '0;
      h_ref_valid_q <= 1'b0;
      h_total_q     <= '0;
      v_total_q     <= '0;
      x_q           <= '0;
      y_q           <= '0;
      active_q      <= 1'b0;
      locked_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      hs_prev_q     <= hs_prev_d;
      vs_prev_q     <= vs_prev_d;
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      h_ref_q       <= h_ref_d;
      h_ref_valid_q <= h_ref_valid_d;
      h_total_q     <= h_total_d;
      v_total_q     <= v_total_d;
      x_q           <= x_d;
      y_q           <= y_d;
      active_q      <= active_d;
      locked_q      <= locked_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      error_q       <= error_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign active      = active_q;
  assign locked      = locked_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign h_total     = h_total_q;
  assign v_total     = v_total_q;
  assign error       = error_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Self-checking bench for vga_sync_decoder using a reduced raster
// (100 strobes/line, 40 lines/frame) so several frames fit in a short run.
module tb_vga_sync_decoder;

  localparam int HBP  = 8;
  localparam int HACT = 64;
  localparam int VBP  = 4;
  localparam int VACT = 30;
  localparam int HT   = 100;
  localparam int HSW  = 12;
  localparam int VT   = 40;
  localparam int VSW  = 2;

  typedef struct {
    int         l;
    int         h;
    logic       active;
    logic [9:0] x;
    logic [8:0] y;
    logic       line_start;
    logic       frame_start;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n, pixel_strobe, hsync, vsync, mode;
  logic [9:0] x, h_total, v_total;
  logic [8:0] y;
  logic       active, locked, line_start, frame_start, error;

  int   errors = 0;
  int   checks = 0;
  int   hpos, lpos, vs_edges;
  logic last_vs;
  exp_t sb[$];

  vga_sync_decoder #(
    .H_BACK_PORCH(HBP), .H_ACTIVE(HACT), .V_BACK_PORCH(VBP), .V_ACTIVE(VACT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pixel_strobe(pixel_strobe),
    .hsync(hsync), .vsync(vsync), .mode(mode),
    .x(x), .y(y), .active(active), .locked(locked),
    .line_start(line_start), .frame_start(frame_start),
    .h_total(h_total), .v_total(v_total), .error(error)
  );

  always #5 clk = ~clk;

  // Raster source: hsync low in the last HSW strobes of each line,
  // vsync rises HBP strobes into line 0 and is low for VSW lines before that.
  function automatic logic ras_hs(int h);
    return (h < HT - HSW);
  endfunction

  function automatic logic ras_vs(int l, int h);
    int g;
    g = l * HT + h;
    return !(g < HBP || g >= (VT - VSW) * HT + HBP);
  endfunction

  // Expected outputs of a locked decoder for a given raster position.
  function automatic exp_t model(int l, int h, logic md);
    exp_t e;
    int   vcnt;
    vcnt          = (l == 0 && h < HBP) ? VT : l;
    e.l           = l;
    e.h           = h;
    e.active      = (h >= HBP) && (h < HBP + HACT) && (vcnt >= VBP) && (vcnt < VBP + VACT);
    e.x           = e.active ? 10'((h - HBP) >> md) : 10'd0;
    e.y           = e.active ? 9'((vcnt - VBP) >> md) : 9'd0;
    e.line_start  = (h == 0);
    e.frame_start = (l == 0 && h == HBP);
    return e;
  endfunction

  task automatic step(input logic hs, input logic vs);
    pixel_strobe = 1'b1;
    hsync        = hs;
    vsync        = vs;
    if (vs && !last_vs) vs_edges++;
    last_vs = vs;
    @(posedge clk);
    #1;
    pixel_strobe = 1'b0;
  endtask

  task automatic idle();
    pixel_strobe = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic ras_step();
    step(ras_hs(hpos), ras_vs(lpos, hpos));
    hpos++;
    if (hpos == HT) begin
      hpos = 0;
      lpos = (lpos + 1) % VT;
    end
  endtask

  task automatic run_to_edges(input int n);
    int target;
    target = vs_edges + n;
    while (vs_edges < target) ras_step();
  endtask

  task automatic advance_to(input int l, input int h);
    for (int i = 0; i < 2 * VT * HT && !(lpos == l && hpos == h); i++) ras_step();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; pixel_strobe = 1'b0; hsync = 1'b1; vsync = 1'b1; mode = 1'b0;
    last_vs = 1'b1; vs_edges = 0;
    #12;
    checks++;
    if ({x, y, active, locked, line_start, frame_start, h_total, v_total, error} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=0",
               {x, y, active, locked, line_start, frame_start, h_total, v_total, error});
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle();
    checks++;
    if ({locked, error, active} !== 3'b000) begin
      errors++;
      $display("FAIL reset_release got=%b exp=000", {locked, error, active});
    end
  endtask

  task automatic test_lock();
    int target;
    hpos = 0; lpos = VT - 20;
    run_to_edges(1);
    checks++;
    if ({locked, frame_start} !== 2'b00) begin
      errors++;
      $display("FAIL lock_first_edge got=%b exp=00", {locked, frame_start});
    end
    target = vs_edges + 1;
    while (vs_edges < target) begin
      ras_step();
      if (vs_edges < target) begin
        checks++;
        if ({locked, error} !== 2'b00) begin
          errors++;
          $display("FAIL lock_measure l=%0d h=%0d got=%b exp=00", lpos, hpos, {locked, error});
        end
      end
    end
    checks++;
    if ({locked, frame_start, error} !== 3'b110) begin
      errors++;
      $display("FAIL lock_second_edge got=%b exp=110", {locked, frame_start, error});
    end
    checks++;
    if (h_total !== 10'd100 || v_total !== 10'd40) begin
      errors++;
      $display("FAIL lock_totals got=%0d/%0d exp=100/40", h_total, v_total);
    end
  endtask

  task automatic test_active(input logic md);
    exp_t e, g;
    mode = md;
    for (int i = 0; i < VT * HT; i++) begin
      e = model(lpos, hpos, md);
      sb.push_back(e);
      ras_step();
      g = sb.pop_front();
      checks++;
      if ({active, x, y, locked, line_start, frame_start, error} !==
          {g.active, g.x, g.y, 1'b1, g.line_start, g.frame_start, 1'b0}) begin
        errors++;
        $display("FAIL raster md=%0b l=%0d h=%0d got=%h exp=%h", md, g.l, g.h,
                 {active, x, y, locked, line_start, frame_start, error},
                 {g.active, g.x, g.y, 1'b1, g.line_start, g.frame_start, 1'b0});
      end
      if ((g.l == 5 && g.h == 20) || (g.l == 6 && g.h == 0)) begin
        idle();
        checks++;
        if ({active, x, y, line_start} !== {g.active, g.x, g.y, 1'b0}) begin
          errors++;
          $display("FAIL hold_idle l=%0d h=%0d got=%h exp=%h", g.l, g.h,
                   {active, x, y, line_start}, {g.active, g.x, g.y, 1'b0});
        end
      end
      if (md && g.l == 33 && g.h == 71) begin
        mode = 1'b0;
        idle();
        checks++;
        if (x !== 10'd63 || y !== 9'd29) begin
          errors++;
          $display("FAIL mode_switch_full got=%0d,%0d exp=63,29", x, y);
        end
        mode = 1'b1;
        idle();
        checks++;
        if (x !== 10'd31 || y !== 9'd14) begin
          errors++;
          $display("FAIL mode_switch_half got=%0d,%0d exp=31,14", x, y);
        end
      end
    end
  endtask

  task automatic test_short_line();
    mode = 1'b0;
    advance_to(10, 0);
    ras_step();
    for (int h = 1; h < HT - 1; h++) step(h < HT - HSW - 1, 1'b1);
    hpos = 0; lpos = 11;
    ras_step();
    checks++;
    if ({error, locked, active, line_start} !== 4'b1000) begin
      errors++;
      $display("FAIL short_line_error got=%b exp=1000", {error, locked, active, line_start});
    end
    ras_step();
    checks++;
    if ({error, locked} !== 2'b00) begin
      errors++;
      $display("FAIL short_line_pulse got=%b exp=00", {error, locked});
    end
    run_to_edges(1);
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL short_relock_early got=%b exp=0", locked);
    end
    run_to_edges(1);
    checks++;
    if (locked !== 1'b1 || h_total !== 10'd100) begin
      errors++;
      $display("FAIL short_relock got=%b/%0d exp=1/100", locked, h_total);
    end
  endtask

  task automatic test_timeout();
    advance_to(10, 1);
    for (int i = 1; i <= 1100; i++) begin
      step(1'b1, 1'b1);
      if (i == 1022) begin
        checks++;
        if ({error, locked} !== 2'b01) begin
          errors++;
          $display("FAIL timeout_before got=%b exp=01", {error, locked});
        end
      end
      if (i == 1023) begin
        checks++;
        if ({error, locked, active, x, y} !== {3'b100, 19'd0}) begin
          errors++;
          $display("FAIL timeout_error got=%h exp=%h", {error, locked, active, x, y}, {3'b100, 19'd0});
        end
      end
      if (i == 1024 || i == 1100) begin
        checks++;
        if ({error, locked} !== 2'b00) begin
          errors++;
          $display("FAIL timeout_after i=%0d got=%b exp=00", i, {error, locked});
        end
      end
    end
    hpos = HT - HSW; lpos = 10;
    run_to_edges(1);
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL timeout_relock_early got=%b exp=0", locked);
    end
    run_to_edges(1);
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL timeout_relock got=%b exp=1", locked);
    end
  endtask

  task automatic test_reset_mid();
    advance_to(15, 40);
    checks++;
    if ({locked, active} !== 2'b11 || x !== 10'd31) begin
      errors++;
      $display("FAIL pre_reset got=%b x=%0d exp=11 x=31", {locked, active}, x);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({x, y, active, locked, line_start, frame_start, h_total, v_total, error} !== '0) begin
      errors++;
      $display("FAIL async_reset got=%h exp=0",
               {x, y, active, locked, line_start, frame_start, h_total, v_total, error});
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    last_vs = 1'b1;
    run_to_edges(1);
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL reset_relock_early got=%b exp=0", locked);
    end
    run_to_edges(1);
    checks++;
    if (locked !== 1'b1 || h_total !== 10'd100 || v_total !== 10'd40) begin
      errors++;
      $display("FAIL reset_relock got=%b %0d/%0d exp=1 100/40", locked, h_total, v_total);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_active(1'b0);
    test_active(1'b1);
    test_short_line();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/vga_sync_decoder.md
# vga_sync_decoder

Receive-side VGA timing decoder. It samples an incoming active-low hsync/vsync pair on the pixel strobe and measures line and frame lengths. It locks onto a stable raster and regenerates the active-area flag and pixel coordinates (x, y) for a downstream capture or monitor path. It is the counterpart of the VGA timing generator: it consumes that generator's sync outputs, or any compatible source on the same clock.

## Interface
- `H_BACK_PORCH`, 48, strobes from hsync rising edge (sync end) to first active pixel
- `H_ACTIVE`, 640, active pixels per line
- `V_BACK_PORCH`, 32, lines from vsync rising edge to first active line
- `V_ACTIVE`, 480, active lines per frame
- `clk  in  1`  system clock
- `reset_n  in  1`  reset, asynchronous, active-low
- `pixel_strobe  in  1`  pixel-rate enable; all state advances only when high
- `hsync  in  1`  horizontal sync, active-low, synchronous to `clk`
- `vsync  in  1`  vertical sync, active-low, synchronous to `clk`
- `mode  in  1`  0: full resolution; 1: x and y halved
- `x  out  10`  active pixel column (>> mode), 0 outside active
- `y  out  9`  active line (>> mode), 0 outside active
- `active  out  1`  high on active pixels while locked
- `locked  out  1`  raster lock status
- `line_start  out  1`  one-clock pulse on each hsync rising edge while locked
- `frame_start  out  1`  one-clock pulse on each vsync rising edge while locked
- `h_total  out  10`  measured strobes per line (last accepted)
- `v_total  out  10`  measured lines per frame (last accepted)
- `error  out  1`  one-clock pulse on lock loss or timeout

## Operation
- Sync inputs are same-clock signals with no synchronizer. On each strobe the block registers `hs_prev`/`vs_prev`. A rising edge is current sample 1 with prev 0.
- `hc`: 10-bit strobe counter. Cleared to 0 on the hsync-rising strobe, otherwise increments, saturating at 1023. `line_len` = hc+1 taken at the edge.
- `vc`: 10-bit line counter. Increments on each hsync rising edge, saturating at 1023. Cleared to 0 on the vsync-rising strobe. If both edges occur on the same strobe, vsync wins (vc=0). `frame_len` = vc value at the vsync edge.
- FSM:
  - SEARCH: locked=0. On vsync rising edge → MEASURE; capture h_ref from the next hsync edge.
  - MEASURE: every hsync edge with line_len≠h_ref → error, SEARCH. At the next vsync edge, h_total←h_ref, v_total←frame_len → LOCKED.
  - LOCKED: locked=1. Any line_len≠h_total, or frame_len≠v_total → error pulse, SEARCH.
- Timeout: hc reaching 1023 in any state other than SEARCH → error pulse, SEARCH.
- active = LOCKED ∧ H_BACK_PORCH ≤ hc < H_BACK_PORCH+H_ACTIVE ∧ V_BACK_PORCH ≤ vc < V_BACK_PORCH+V_ACTIVE.
- x = (hc−H_BACK_PORCH)>>mode and y = (vc−V_BACK_PORCH)>>mode when active, else 0. Subtraction is 10-bit; y is truncated to 9 bits.
- h_total and v_total hold their values through SEARCH/MEASURE until the next lock.

## Timing
- Reset values: x=0, y=0, active=0, locked=0, line_start=0, frame_start=0, h_total=0, v_total=0, error=0, state SEARCH, hc=0, vc=0, hs_prev=vs_prev=1.
- All outputs are registered. They reflect the strobe sampled on the previous clock edge, giving 1 clk latency from strobe to output.
- Pulses (line_start, frame_start, error) last exactly 1 clk, not 1 strobe period.
- Outputs hold between strobes.
- Deasserting reset mid-frame restarts from SEARCH; no stale lock.
- mode is sampled each clk and may change any time; x/y follow on the next clk.

## Test plan
- Clean raster (800 strobes/line, hsync low 96, 525 lines, vsync low 2) -> locked rises 1 clk after the second vsync rising edge; h_total=800, v_total=525.
- Locked, default params -> active first high at hc=48, vc=32 with x=0, y=0; at hc=687, vc=511, x=639, y=479; active low at hc=688.
- Same as above with mode=1 at hc=687, vc=511 -> x=319, y=239.
- While locked, one 799-strobe line -> single error pulse, locked=0, active=0; relock after two further vsync edges.
- hsync held high while locked -> error pulse when hc reaches 1023; FSM in SEARCH; x=y=0.
- reset_n asserted mid-line while locked -> all outputs 0 immediately (asynchronous); relock after two vsync edges.
